// File: rtl/indication_pipe_serializer.sv
// Buffers whole indication messages in a small FIFO and emits each one as NW words, word 0 first.
// Word 0 appears right after the enqueue edge. Enqueue ready depends on FIFO occupancy only, and a word is held until out_ready.
module indication_pipe_serializer #(
  parameter int MSG_WIDTH  = 96,
  parameter int WORD_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  pipe_enq__ENA,
  input  logic [MSG_WIDTH-1:0]  pipe_enq_v,
  output logic                  pipe_enq__RDY,
  output logic                  out_valid,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic [15:0]           msg_count
);

  localparam int NW = MSG_WIDTH / WORD_WIDTH;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {EMPTY, SEND} state_t;

  state_t               state, state_nxt;
  logic [MSG_WIDTH-1:0] mem [DEPTH];
  logic [MSG_WIDTH-1:0] head;
  logic [PW-1:0]        wptr, rptr;
  logic [CW-1:0]        count;
  logic [IW-1:0]        idx;
  logic                 enq_fire, pop, last_pop, at_last;

  always_comb begin
    state_nxt     = state;
    out_data      = '0;
    out_last      = 1'b0;
    head          = mem[rptr];
    // Ready depends on stored occupancy only, so a full FIFO refuses even when the head is leaving.
    pipe_enq__RDY = (count < CW'(DEPTH));
    enq_fire      = pipe_enq__ENA && pipe_enq__RDY && nRST;
    out_valid     = (state == SEND);
    at_last       = (idx == IW'(NW - 1));
    pop           = out_valid && out_ready;
    last_pop      = pop && at_last;
    if (out_valid) begin
      out_data = head[WORD_WIDTH*int'(idx) +: WORD_WIDTH];
      out_last = at_last;
    end
    case (state)
      EMPTY:   if (enq_fire) state_nxt = SEND;
      SEND:    if (last_pop && !enq_fire && count == CW'(1)) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= EMPTY;
      count     <= '0;
      wptr      <= '0;
      rptr      <= '0;
      idx       <= '0;
      msg_count <= '0;
    end else begin
      state <= state_nxt;
      if (enq_fire) wptr <= wptr + 1'b1;
      if (last_pop) begin
        rptr      <= rptr + 1'b1;
        idx       <= '0;
        msg_count <= msg_count + 16'd1;
      end else if (pop) begin
        idx <= idx + 1'b1;
      end
      case ({enq_fire, last_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (enq_fire) mem[wptr] <= pipe_enq_v;
  end

endmodule

// File: tb/tb_indication_pipe_serializer.sv
// Directed bench for indication_pipe_serializer with a word scoreboard fed at enqueue and drained at output.
module tb_indication_pipe_serializer;

  logic        CLK;
  logic        nRST;
  logic        ena, out_ready, rdy, out_valid, out_last;
  logic [95:0] v;
  logic [31:0] out_data;
  logic [15:0] msg_count;

  // Single-word variant: one message per cycle keeps the msg_count wrap test short.
  logic        a_ena, a_rdy, a_valid, a_last;
  logic [31:0] a_v, a_data;
  logic [15:0] a_count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [32:0] sb[$];
  int          mdl_cnt   = 0;
  logic [15:0] exp_msgs  = '0;
  int          words_out = 0;
  logic        stalled   = 1'b0;
  logic [31:0] prev_d;
  logic        prev_l;
  int          snap, n;

  indication_pipe_serializer dut (
    .CLK(CLK), .nRST(nRST),
    .pipe_enq__ENA(ena), .pipe_enq_v(v), .pipe_enq__RDY(rdy),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .msg_count(msg_count)
  );

  indication_pipe_serializer #(.MSG_WIDTH(32), .WORD_WIDTH(32), .DEPTH(2)) dut1 (
    .CLK(CLK), .nRST(nRST),
    .pipe_enq__ENA(a_ena), .pipe_enq_v(a_v), .pipe_enq__RDY(a_rdy),
    .out_valid(a_valid), .out_data(a_data), .out_last(a_last),
    .out_ready(1'b1), .msg_count(a_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic enq(input logic [95:0] m);
    ena = 1'b1;
    v   = m;
    tick();
    ena = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int k = 0;
    while (out_valid && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 96'(out_valid), 96'(0));
  endtask

  function automatic logic [95:0] mk(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
    return {w2, w1, w0};
  endfunction

  // Scoreboard: words pushed on modelled acceptance, popped on each observed transfer.
  always @(negedge CLK) begin
    logic acc;
    if (!nRST) begin
      sb.delete();
      mdl_cnt  = 0;
      exp_msgs = '0;
      stalled  = 1'b0;
      chk("rst_valid", 96'(out_valid), 96'(0));
      chk("rst_data", 96'(out_data), 96'(0));
      chk("rst_rdy", 96'(rdy), 96'(1));
      chk("rst_msg_count", 96'(msg_count), 96'(0));
    end else begin
      acc = ena && (mdl_cnt < 2);
      chk("valid", 96'(out_valid), 96'(sb.size() > 0));
      chk("rdy", 96'(rdy), 96'(mdl_cnt < 2));
      chk("msg_count", 96'(msg_count), 96'(exp_msgs));
      if (stalled) begin
        chk("stall_data", 96'(out_data), 96'(prev_d));
        chk("stall_last", 96'(out_last), 96'(prev_l));
      end
      if (out_valid && sb.size() > 0) begin
        chk("data", 96'(out_data), 96'(sb[0][31:0]));
        chk("last", 96'(out_last), 96'(sb[0][32]));
        if (out_ready) begin
          if (sb[0][32]) begin
            mdl_cnt--;
            exp_msgs = exp_msgs + 16'd1;
          end
          void'(sb.pop_front());
          words_out++;
        end
      end
      stalled = out_valid && !out_ready;
      prev_d  = out_data;
      prev_l  = out_last;
      if (acc) begin
        sb.push_back({1'b0, v[31:0]});
        sb.push_back({1'b0, v[63:32]});
        sb.push_back({1'b1, v[95:64]});
        mdl_cnt++;
      end
    end
  end

  initial begin
    nRST = 1'b0; ena = 1'b0; v = '0; out_ready = 1'b0;
    a_ena = 1'b0; a_v = '0;
    #1;
    chk("reset_valid", 96'(out_valid), 96'(0));
    chk("reset_rdy", 96'(rdy), 96'(1));
    chk("reset_last", 96'(out_last), 96'(0));
    tick(); tick();
    nRST = 1'b1;
    tick();

    // 1: single message, words on consecutive cycles
    out_ready = 1'b1;
    enq(96'h000000030000000200000001);
    chk("t1_w0", 96'(out_data), 96'(1));
    tick();
    chk("t1_w1", 96'(out_data), 96'(2));
    chk("t1_w1_last", 96'(out_last), 96'(0));
    tick();
    chk("t1_w2", 96'(out_data), 96'(3));
    chk("t1_w2_last", 96'(out_last), 96'(1));
    tick();
    chk("t1_idle", 96'(out_valid), 96'(0));
    chk("t1_count", 96'(msg_count), 96'(1));

    // 2: third back-to-back enqueue refused while full
    out_ready = 1'b0;
    ena = 1'b1;
    v = mk(32'hA0, 32'hA1, 32'hA2); tick();
    v = mk(32'hB0, 32'hB1, 32'hB2); tick();
    chk("t2_rdy_full", 96'(rdy), 96'(0));
    v = mk(32'hC0, 32'hC1, 32'hC2); tick();
    chk("t2_rdy_still_full", 96'(rdy), 96'(0));
    ena = 1'b0;
    snap = words_out;
    out_ready = 1'b1;
    drain("t2_drain", 20);
    chk("t2_words", 96'(words_out - snap), 96'(6));
    chk("t2_count", 96'(msg_count), 96'(3));

    // 3: no bypass on a full FIFO popping its last word
    out_ready = 1'b0;
    enq(mk(32'hD0, 32'hD1, 32'hD2));
    enq(mk(32'hE0, 32'hE1, 32'hE2));
    out_ready = 1'b1;
    n = 0;
    while (!out_last && n < 10) begin tick(); n++; end
    chk("t3_at_last", 96'(out_last), 96'(1));
    ena = 1'b1;
    v = mk(32'hF0, 32'hF1, 32'hF2);
    chk("t3_rdy_blocked", 96'(rdy), 96'(0));
    tick();
    chk("t3_rdy_retry", 96'(rdy), 96'(1));
    tick();
    ena = 1'b0;
    drain("t3_drain", 20);
    chk("t3_count", 96'(msg_count), 96'(6));

    // 4: random stalls mid-message
    out_ready = 1'b0;
    enq(96'h000000030000000200000001);
    tick();
    n = 0;
    while (out_valid && n < 200) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    chk("t4_drain", 96'(out_valid), 96'(0));
    chk("t4_count", 96'(msg_count), 96'(7));

    // 5: reset mid-message
    out_ready = 1'b1;
    enq(mk(32'h11, 32'h22, 32'h33));
    chk("t5_w0", 96'(out_data), 96'(32'h11));
    tick();
    chk("t5_w1", 96'(out_data), 96'(32'h22));
    #2;
    nRST = 1'b0;
    #1;
    chk("t5_valid", 96'(out_valid), 96'(0));
    chk("t5_count", 96'(msg_count), 96'(0));
    chk("t5_data", 96'(out_data), 96'(0));
    tick(); tick();
    nRST = 1'b1;
    tick();
    enq(mk(32'hA, 32'hB, 32'hC));
    chk("t5_restart_w0", 96'(out_data), 96'(32'hA));
    drain("t5_drain", 10);
    chk("t5_count_after", 96'(msg_count), 96'(1));

    // 6: msg_count wrap on the single-word variant
    a_ena = 1'b1;
    for (int i = 1; i <= 65535; i++) begin
      a_v = 32'(i);
      tick();
      if (i % 16384 == 0) begin
        chk("t6_data", 96'(a_data), 96'(i));
        chk("t6_last", 96'(a_last), 96'(1));
      end
    end
    a_ena = 1'b0;
    n = 0;
    while (a_valid && n < 10) begin tick(); n++; end
    chk("t6_drain", 96'(a_valid), 96'(0));
    chk("t6_count_ffff", 96'(a_count), 96'(16'hFFFF));
    a_ena = 1'b1;
    a_v = 32'h5A5A;
    tick();
    a_ena = 1'b0;
    chk("t6_data_last", 96'(a_data), 96'(32'h5A5A));
    tick();
    chk("t6_count_wrap", 96'(a_count), 96'(0));
    chk("t6_rdy", 96'(a_rdy), 96'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
